// File: rtl/instr_loader.sv
// instr_loader: buffers a host-written program, streams it into the CPU one word per clock, then pulses the CPU reset and releases it to RUN.
// Latency: start sampled at edge T -> words on Instruction T+1..T+n, cpu_Reset high RESET_CYCLES cycles, done at T+1+n+RESET_CYCLES.
// Backpressure: wr_ready low during LOAD/RESET and when the buffer is full; optional checksum port under LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter int DEPTH        = 32,
  parameter int RESET_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  input  logic                     start,
  input  logic                     clear,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   word_count,
  output logic                     LoadInstructions,
  output logic [31:0]              Instruction,
  output logic                     cpu_Reset
`ifdef LOADER_CHECKSUM_EN
  ,output logic [31:0]             checksum
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int RCW = $clog2(RESET_CYCLES + 1);

  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_C   = CW'(1);
  localparam logic [RCW-1:0] RC_C    = RCW'(RESET_CYCLES);
  localparam logic [RCW-1:0] ONE_R   = RCW'(1);
  localparam logic [AW-1:0]  ZERO_A  = '0;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESET, S_RUN} state_t;

  state_t         state;
  logic [31:0]    mem [DEPTH];
  logic [CW-1:0]  n_words;
  logic [CW-1:0]  idx;
  logic [RCW-1:0] rst_cnt;

  logic           accept;
  logic [CW-1:0]  eff_count;
  logic [CW-1:0]  idx_nxt;

  // Write handshake and the word count a same-cycle start would see
  always_comb begin
    wr_ready  = ((state == S_IDLE) || (state == S_RUN)) && (word_count < DEPTH_C);
    accept    = wr_valid && wr_ready;
    eff_count = accept ? (word_count + ONE_C) : word_count;
    idx_nxt   = idx + ONE_C;
  end

  // Program buffer: append at word_count; clear wins over a same-cycle write
  always_ff @(posedge clk) begin
    if (accept && !clear) begin
      mem[word_count[AW-1:0]] <= wr_data;
    end
  end

  // Control FSM with registered CPU-facing outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state            <= S_IDLE;
      word_count       <= '0;
      n_words          <= '0;
      idx              <= '0;
      rst_cnt          <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      LoadInstructions <= 1'b0;
      Instruction      <= '0;
      cpu_Reset        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      checksum         <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (clear) begin
        state            <= S_IDLE;
        word_count       <= '0;
        idx              <= '0;
        rst_cnt          <= '0;
        busy             <= 1'b0;
        LoadInstructions <= 1'b0;
        Instruction      <= '0;
        cpu_Reset        <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
        checksum         <= '0;
`endif
      end else begin
        case (state)
          S_IDLE, S_RUN: begin
            word_count <= eff_count;
            if (start && (eff_count != '0)) begin
              state            <= S_LOAD;
              n_words          <= eff_count;
              idx              <= '0;
              busy             <= 1'b1;
              LoadInstructions <= 1'b1;
              cpu_Reset        <= 1'b0;
              // With an empty buffer, word 0 is the write landing this very edge
              Instruction      <= (word_count == '0) ? wr_data : mem[ZERO_A];
`ifdef LOADER_CHECKSUM_EN
              checksum         <= '0;
`endif
            end
          end
          S_LOAD: begin
`ifdef LOADER_CHECKSUM_EN
            checksum <= checksum ^ Instruction;
`endif
            if (idx_nxt < n_words) begin
              idx         <= idx_nxt;
              Instruction <= mem[idx_nxt[AW-1:0]];
            end else begin
              state            <= S_RESET;
              LoadInstructions <= 1'b0;
              Instruction      <= '0;
              cpu_Reset        <= 1'b1;
              rst_cnt          <= ONE_R;
            end
          end
          S_RESET: begin
            if (rst_cnt == RC_C) begin
              state     <= S_RUN;
              cpu_Reset <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              rst_cnt <= rst_cnt + ONE_R;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed stimulus against a schedule-based model of instr_loader.
// The model builds the expected per-cycle output trace of a whole load when start is accepted.
// Checksum checks are included when LOADER_CHECKSUM_EN is defined.
module tb_instr_loader;

  localparam int DEPTH = 32;
  localparam int RC    = 1;

  logic        clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic [5:0]  word_count;
  logic        LoadInstructions;
  logic [31:0] Instruction;
  logic        cpu_Reset;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  instr_loader #(.DEPTH(DEPTH), .RESET_CYCLES(RC)) dut (
    .clk              (clk),
    .Reset_n          (Reset_n),
    .wr_valid         (wr_valid),
    .wr_data          (wr_data),
    .wr_ready         (wr_ready),
    .start            (start),
    .clear            (clear),
    .busy             (busy),
    .done             (done),
    .word_count       (word_count),
    .LoadInstructions (LoadInstructions),
    .Instruction      (Instruction),
    .cpu_Reset        (cpu_Reset)
`ifdef LOADER_CHECKSUM_EN
    ,.checksum        (checksum)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic        li;
    logic [31:0] ins;
    logic        cr;
    logic        bz;
    logic        dn;
  } exp_t;

  function automatic exp_t mk(input logic li, input logic [31:0] ins, input logic cr,
                              input logic bz, input logic dn);
    exp_t e;
    e.li = li; e.ins = ins; e.cr = cr; e.bz = bz; e.dn = dn;
    return e;
  endfunction

  exp_t        cur = 35'b0_00000000000000000000000000000000_1_0_0;
  logic [31:0] wbuf[$];
  exp_t        sched[$];
  bit          ran = 1'b0;
  logic [31:0] cks = '0;

  // Expected outputs for the cycle following each edge
  always @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wbuf.delete();
      sched.delete();
      ran = 1'b0;
      cks = '0;
      cur = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end else begin
      if (cur.li) cks = cks ^ cur.ins;
      if (clear) begin
        wbuf.delete();
        sched.delete();
        ran = 1'b0;
        cks = '0;
        cur = mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end else if (sched.size() > 0) begin
        cur = sched.pop_front();
        if (cur.dn) ran = 1'b1;
      end else begin
        if (wr_valid && wbuf.size() < DEPTH) wbuf.push_back(wr_data);
        if (start && wbuf.size() > 0) begin
          foreach (wbuf[i]) sched.push_back(mk(1'b1, wbuf[i], 1'b0, 1'b1, 1'b0));
          for (int k = 0; k < RC; k++) sched.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0));
          sched.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1));
          cks = '0;
          cur = sched.pop_front();
        end else begin
          cur = mk(1'b0, 32'h0, !ran, 1'b0, 1'b0);
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    chk("m_LoadInstructions", {31'b0, LoadInstructions}, {31'b0, cur.li});
    chk("m_Instruction", Instruction, cur.ins);
    chk("m_cpu_Reset", {31'b0, cpu_Reset}, {31'b0, cur.cr});
    chk("m_busy", {31'b0, busy}, {31'b0, cur.bz});
    chk("m_done", {31'b0, done}, {31'b0, cur.dn});
    chk("m_word_count", {26'b0, word_count}, wbuf.size());
    chk("m_wr_ready", {31'b0, wr_ready}, {31'b0, (!cur.bz && wbuf.size() < DEPTH)});
`ifdef LOADER_CHECKSUM_EN
    chk("m_checksum", checksum, cks);
`endif
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] w3 [3] = '{32'h200101A7, 32'h2002005C, 32'h2003000D};

  task automatic cyc(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  initial begin
    int dn;
    cyc(2);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    chk("rst_cpu_Reset", {31'b0, cpu_Reset}, 32'd1);
    chk("rst_word_count", {26'b0, word_count}, 32'd0);
    chk("rst_li", {31'b0, LoadInstructions}, 32'd0);
    Reset_n = 1'b1;
    cyc();

    // three-word program
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = w3[i]; cyc();
    end
    wr_valid = 1'b0;
    chk("wc_after_3", {26'b0, word_count}, 32'd3);
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("load3_ins", Instruction, w3[i]);
      chk("load3_li", {31'b0, LoadInstructions}, 32'd1);
      chk("load3_busy", {31'b0, busy}, 32'd1);
      cyc();
    end
    chk("load3_reset", {31'b0, cpu_Reset}, 32'd1);
    chk("load3_reset_busy", {31'b0, busy}, 32'd1);
    cyc();
    chk("load3_done", {31'b0, done}, 32'd1);
    chk("load3_run_cr", {31'b0, cpu_Reset}, 32'd0);
    chk("load3_run_busy", {31'b0, busy}, 32'd0);
    cyc();
    chk("load3_done_pulse", {31'b0, done}, 32'd0);

    // append one word in RUN, then clear during the second of four load cycles
    wr_valid = 1'b1; wr_data = 32'hA5A50004; cyc(); wr_valid = 1'b0;
    chk("wc_after_4", {26'b0, word_count}, 32'd4);
    start = 1'b1; cyc(); start = 1'b0;
    chk("clr_load_w0", Instruction, 32'h200101A7);
    cyc();
    chk("clr_load_w1", Instruction, 32'h2002005C);
    clear = 1'b1; cyc(); clear = 1'b0;
    chk("clr_li", {31'b0, LoadInstructions}, 32'd0);
    chk("clr_cr", {31'b0, cpu_Reset}, 32'd1);
    chk("clr_wc", {26'b0, word_count}, 32'd0);
    dn = 0;
    repeat (8) begin
      if (done) dn++;
      cyc();
    end
    chk("clr_no_done", dn, 32'd0);

    // start on empty buffer is ignored
    start = 1'b1; cyc(); start = 1'b0;
    repeat (3) begin
      chk("empty_li", {31'b0, LoadInstructions}, 32'd0);
      chk("empty_cr", {31'b0, cpu_Reset}, 32'd1);
      cyc();
    end

    // start together with the first write: n = 1
    wr_valid = 1'b1; wr_data = 32'hDEADBEEF; start = 1'b1; cyc();
    wr_valid = 1'b0; start = 1'b0;
    chk("n1_ins", Instruction, 32'hDEADBEEF);
    cyc();
    chk("n1_reset", {31'b0, cpu_Reset}, 32'd1);
    cyc();
    chk("n1_done", {31'b0, done}, 32'd1);
    cyc();

    // fill the buffer, then offer one more word
    clear = 1'b1; cyc(); clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = 32'h10000000 + i; cyc();
    end
    wr_data = 32'hBAD0BAD0;
    chk("full_wr_ready", {31'b0, wr_ready}, 32'd0);
    cyc(2);
    chk("full_wc", {26'b0, word_count}, 32'd32);
    wr_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("full_w0", Instruction, 32'h10000000);
    cyc(31);
    chk("full_w31", Instruction, 32'h1000001F);
    cyc();
    chk("full_after_li", {31'b0, LoadInstructions}, 32'd0);
    cyc();
    chk("full_done", {31'b0, done}, 32'd1);
    cyc();

    // reload from RUN, then async reset mid-load
    start = 1'b1; cyc(); start = 1'b0;
    chk("reload_w0", Instruction, 32'h10000000);
    cyc();
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_li", {31'b0, LoadInstructions}, 32'd0);
    chk("arst_cr", {31'b0, cpu_Reset}, 32'd1);
    chk("arst_wc", {26'b0, word_count}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ins", Instruction, 32'd0);
    cyc();
    Reset_n = 1'b1;
    cyc();

`ifdef LOADER_CHECKSUM_EN
    wr_valid = 1'b1; wr_data = 32'h0000000F; cyc();
    wr_data = 32'h000000F0; cyc(); wr_valid = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    cyc(2);
    chk("cks_first", checksum, 32'h000000FF);
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    cyc(2);
    chk("cks_reload", checksum, 32'h000000FF);
    cyc(2);
`endif

    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Host-side driver for the CPU's instruction-load interface. It buffers a program written by a host over a valid/ready port, then streams it into the CPU one word per clock on `LoadInstructions`/`Instruction`. After the last word it pulses the CPU reset and releases the CPU to run. It sits between the host (or a test harness) and the CPU's `LoadInstructions`, `Instruction` and `Reset` inputs.

## Interface
- `DEPTH`, 32: program buffer depth in 32-bit words; power of two, minimum 2.
- `RESET_CYCLES`, 1: number of cycles `cpu_Reset` is held high after the load, minimum 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `wr_valid`  in  1: host offers `wr_data`.
- `wr_data`  in  32: instruction word to append.
- `wr_ready`  out  1: a write is accepted on a cycle where `wr_valid && wr_ready`.
- `start`  in  1: level sampled each cycle; begins a load.
- `clear`  in  1: abort any operation and empty the buffer.
- `busy`  out  1: high in the LOAD and RESET states.
- `done`  out  1: one-cycle pulse on entry to RUN.
- `word_count`  out  $clog2(DEPTH)+1: number of words currently buffered.
- `LoadInstructions`  out  1: to the CPU; high while words are streamed.
- `Instruction`  out  32: to the CPU; the current word.
- `cpu_Reset`  out  1: to the CPU `Reset`; active-high.
- `checksum`  out  32: present only with `LOADER_CHECKSUM_EN`.

## Operation
- States: IDLE, LOAD, RESET, RUN.
- Reset values while `Reset_n` is low (asynchronous):
  - state IDLE; `word_count`=0.
  - `wr_ready`=1, `busy`=0, `done`=0.
  - `LoadInstructions`=0, `Instruction`=0.
  - `cpu_Reset`=1, `checksum`=0.
- IDLE: `cpu_Reset`=1. Writes append to `buf[word_count]`.
- RUN: `cpu_Reset`=0 and the CPU executes. Writes still append to the buffer.
- `wr_ready` = (state is IDLE or RUN) && `word_count` < DEPTH. This is a combinational decode of registered state.
- Full buffer: `wr_ready`=0 and the write is not accepted. No overflow and no wrap-around.
- `start` in IDLE or RUN with an effective count > 0 moves the block to LOAD and latches `n` = effective count.
  - The effective count includes a write accepted in the same cycle.
- `start` with an effective count of 0 is ignored: no state change and no `done`.
- `start` in LOAD or RESET is ignored.
- LOAD:
  - `LoadInstructions`=1, `cpu_Reset`=0.
  - Index `i` runs from 0 to n−1, with `Instruction`=`buf[i]`.
  - After word n−1 the block moves to RESET.
- RESET: `LoadInstructions`=0, `Instruction`=0, `cpu_Reset`=1 for RESET_CYCLES cycles, then RUN.
- The buffer contents are retained after a load, so `start` from RUN reloads the same program plus any words appended since.
- `clear` is honoured in any state. On the next edge:
  - state IDLE, `word_count`=0.
  - `LoadInstructions`=0, `Instruction`=0, `cpu_Reset`=1, `busy`=0.
- `clear` beats `start` and beats a write in the same cycle.
- All outputs to the CPU are registered.

## Timing
- `start` is sampled at edge T:
  - word i is valid on `Instruction` with `LoadInstructions`=1 during cycle T+1+i, for i = 0..n−1.
  - `cpu_Reset`=1 during cycles T+1+n .. T+n+RESET_CYCLES.
  - `done`=1 and `cpu_Reset`=0 during cycle T+1+n+RESET_CYCLES.
- Total latency from `start` to `done` is n+RESET_CYCLES+1 cycles.
- `busy` is high exactly during the LOAD and RESET cycles.
- Write throughput: one word per cycle.
- Load throughput: one word per cycle, with no gaps.
- Asserting `Reset_n` low in the middle of a load drops `LoadInstructions` and raises `cpu_Reset` immediately (asynchronously). The buffer is considered empty after reset.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` is cleared on entry to LOAD.
  - Each word is XORed into `checksum` in the cycle it is streamed.
  - `checksum` is stable from the first RESET cycle until the next load or `clear`.
- `LOADER_CHECKSUM_EN` undefined: the `checksum` port and its logic are absent.

## Test plan
- Write 3 words (0x200101A7, 0x2002005C, 0x2003000D), then pulse `start`:
  - `Instruction` shows the three words on consecutive cycles with `LoadInstructions`=1.
  - `cpu_Reset`=1 for 1 cycle, then `done` and `cpu_Reset`=0.
  - `busy` is high for 4 cycles.
- Fill all DEPTH=32 words, then assert `wr_valid` again: `wr_ready`=0, `word_count` stays 32, and the extra word is never streamed.
- `start` with an empty buffer: no `LoadInstructions`, no `done`, and `cpu_Reset` stays 1.
- Assert `clear` during the second of 4 load cycles:
  - next cycle `LoadInstructions`=0, `cpu_Reset`=1, `word_count`=0.
  - `done` never pulses.
- Drive `Reset_n` low during LOAD: outputs return to their reset values immediately, without waiting for `clk`.
- With `LOADER_CHECKSUM_EN`, load 0x0000000F and 0x000000F0: `checksum`=0x000000FF in RESET. A reload from RUN recomputes the same value.
